// File: rtl/tick_sched_pkg.sv
// rtl/tick_sched_pkg.sv - shared types and constants for the tick scheduler
package tick_sched_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        ARMED = 1'b1
    } chan_state_t;

    localparam int DEFAULT_CUENTA_MAX = 20;

    // Channel index width, never below one bit.
    function automatic int ch_idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tick_prescaler.sv
// rtl/tick_prescaler.sv - base-tick prescaler shared by all timer channels
module tick_prescaler #(
    parameter int CUENTA_MAX = 20,
    parameter int CNT_W      = 22
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    output logic             tick,
    output logic [CNT_W-1:0] cuenta
);

    localparam logic [CNT_W-1:0] CUENTA_TOP = CNT_W'(CUENTA_MAX);

    // Terminal count always wraps, even while paused, so a pending tick is never stretched.
    always_ff @(posedge clk) begin
        if (rst) begin
            cuenta <= '0;
        end else if (cuenta >= CUENTA_TOP) begin
            cuenta <= '0;
        end else if (en) begin
            cuenta <= cuenta + CNT_W'(1);
        end
    end

    assign tick = (cuenta == CUENTA_TOP);

endmodule

// File: rtl/tick_scheduler.sv
// rtl/tick_scheduler.sv - N_CH one-shot/periodic software timers on one shared prescaler
module tick_scheduler
    import tick_sched_pkg::*;
#(
    parameter int CUENTA_MAX = DEFAULT_CUENTA_MAX,
    parameter int CNT_W      = 22,
    parameter int N_CH       = 4,
    parameter int TICK_W     = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       cfg_valid,
    output logic                       cfg_ready,
    input  logic [ch_idx_w(N_CH)-1:0]  cfg_ch,
    input  logic [TICK_W-1:0]          cfg_ticks,
    input  logic                       cfg_periodic,
    output logic                       tick,
    output logic [N_CH-1:0]            busy,
    output logic [N_CH-1:0]            expired
);

    localparam int CH_IDX_W = ch_idx_w(N_CH);

    logic             cfg_fire;
    // Prescaler count is only of interest to debug probes.
    logic [CNT_W-1:0] cuenta_unused;

    tick_prescaler #(
        .CUENTA_MAX (CUENTA_MAX),
        .CNT_W      (CNT_W)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .tick   (tick),
        .cuenta (cuenta_unused)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ready <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
        end
    end

    assign cfg_fire = cfg_valid && cfg_ready;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        chan_state_t       state;
        logic [TICK_W-1:0] remaining;
        logic [TICK_W-1:0] reload;
        logic              periodic;
        logic              pulse;
        logic              hit;

        assign hit = cfg_fire && (cfg_ch == CH_IDX_W'(i));

        // A config on this channel takes priority over a coincident tick.
        always_ff @(posedge clk) begin
            if (rst) begin
                state     <= IDLE;
                remaining <= '0;
                reload    <= '0;
                periodic  <= 1'b0;
                pulse     <= 1'b0;
            end else begin
                pulse <= 1'b0;
                if (hit) begin
                    remaining <= cfg_ticks;
                    reload    <= cfg_ticks;
                    periodic  <= cfg_periodic;
                    state     <= (cfg_ticks != '0) ? ARMED : IDLE;
                end else if (state == ARMED && tick) begin
                    if (remaining > TICK_W'(1)) begin
                        remaining <= remaining - TICK_W'(1);
                    end else begin
                        pulse <= 1'b1;
                        if (periodic) begin
                            remaining <= reload;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
            end
        end

        assign busy[i]    = (state == ARMED);
        assign expired[i] = pulse;
    end

endmodule

// File: tb/tb_tick_scheduler.sv
// tb/tb_tick_scheduler.sv - directed self-checking bench for tick_scheduler
module tb_tick_scheduler;

    localparam int CUENTA_MAX = 4;
    localparam int CNT_W      = 22;
    localparam int N_CH       = 4;
    localparam int TICK_W     = 8;

    logic              clk;
    logic              rst;
    logic              en;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [1:0]        cfg_ch;
    logic [TICK_W-1:0] cfg_ticks;
    logic              cfg_periodic;
    logic              tick;
    logic [N_CH-1:0]   busy;
    logic [N_CH-1:0]   expired;

    int checks = 0;
    int errors = 0;

    tick_scheduler #(
        .CUENTA_MAX (CUENTA_MAX),
        .CNT_W      (CNT_W),
        .N_CH       (N_CH),
        .TICK_W     (TICK_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en           (en),
        .cfg_valid    (cfg_valid),
        .cfg_ready    (cfg_ready),
        .cfg_ch       (cfg_ch),
        .cfg_ticks    (cfg_ticks),
        .cfg_periodic (cfg_periodic),
        .tick         (tick),
        .busy         (busy),
        .expired      (expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Leaves the bench just after the edge that wrapped cuenta to 0.
    task automatic align();
        for (int i = 0; i < 20 && tick !== 1'b1; i++) step();
        chk("align_tick", {31'd0, tick}, 32'd1);
        step();
    endtask

    task automatic cfg(input logic [1:0] ch, input logic [TICK_W-1:0] t, input logic per);
        cfg_valid    = 1'b1;
        cfg_ch       = ch;
        cfg_ticks    = t;
        cfg_periodic = per;
    endtask

    initial begin
        rst          = 1'b1;
        en           = 1'b0;
        cfg_valid    = 1'b0;
        cfg_ch       = '0;
        cfg_ticks    = '0;
        cfg_periodic = 1'b0;

        // Reset
        step(); step(); step();
        chk("rst_busy", {28'd0, busy}, 32'd0);
        chk("rst_expired", {28'd0, expired}, 32'd0);
        chk("rst_tick", {31'd0, tick}, 32'd0);
        chk("rst_ready", {31'd0, cfg_ready}, 32'd0);
        rst = 1'b0;
        chk("ready_before_edge", {31'd0, cfg_ready}, 32'd0);
        step();
        chk("ready_after_rst", {31'd0, cfg_ready}, 32'd1);
        en = 1'b1;

        // One-shot ch0, 3 ticks, accepted at cuenta=0
        align();
        cfg(2'd0, 8'd3, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk("os_busy_rise", {28'd0, busy}, 32'h1);
        for (int k = 2; k <= 16; k++) begin
            step();
            chk("os_expired", {28'd0, expired}, (k == 15) ? 32'h1 : 32'h0);
            chk("os_busy", {28'd0, busy}, (k < 15) ? 32'h1 : 32'h0);
        end

        // Periodic ch1, 2 ticks, four periods then stop
        align();
        cfg(2'd1, 8'd2, 1'b1);
        step();
        cfg_valid = 1'b0;
        for (int k = 2; k <= 41; k++) begin
            step();
            chk("per_expired", {28'd0, expired}, (k % 10 == 0) ? 32'h2 : 32'h0);
            chk("per_busy", {28'd0, busy}, 32'h2);
        end
        cfg(2'd1, 8'd0, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk("per_stop_busy", {28'd0, busy}, 32'h0);
        for (int k = 0; k < 20; k++) begin
            step();
            chk("per_stop_quiet", {28'd0, expired}, 32'h0);
        end

        // Collision: reload ch2 on the tick where remaining==1
        align();
        cfg(2'd2, 8'd2, 1'b0);
        step();
        cfg_valid = 1'b0;
        for (int k = 2; k <= 9; k++) step();
        chk("col_tick_high", {31'd0, tick}, 32'd1);
        cfg(2'd2, 8'd5, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk("col_no_expire", {28'd0, expired}, 32'h0);
        chk("col_busy", {31'd0, busy[2]}, 32'd1);
        for (int k = 11; k <= 36; k++) begin
            step();
            chk("col_expired", {28'd0, expired}, (k == 35) ? 32'h4 : 32'h0);
            chk("col_busy_run", {31'd0, busy[2]}, (k < 35) ? 32'd1 : 32'd0);
        end

        // Pause with ch0 and ch3 armed, then simultaneous expiry
        align();
        cfg(2'd0, 8'd2, 1'b0);
        step();
        cfg(2'd3, 8'd2, 1'b0);
        step();
        cfg_valid = 1'b0;
        for (int k = 3; k <= 6; k++) step();
        en = 1'b0;
        for (int k = 7; k <= 23; k++) begin
            step();
            chk("pause_cuenta", dut.u_prescaler.cuenta, 32'd1);
            chk("pause_tick", {31'd0, tick}, 32'd0);
            chk("pause_busy", {28'd0, busy}, 32'h9);
            chk("pause_expired", {28'd0, expired}, 32'h0);
        end
        en = 1'b1;
        for (int k = 24; k <= 28; k++) begin
            step();
            chk("multi_expired", {28'd0, expired}, (k == 27) ? 32'h9 : 32'h0);
            chk("multi_busy", {28'd0, busy}, (k < 27) ? 32'h9 : 32'h0);
        end

        // Abort: reset while ch0 has one tick left, on the cycle the tick is pending
        align();
        cfg(2'd0, 8'd1, 1'b0);
        step();
        cfg_valid = 1'b0;
        chk("abort_busy_armed", {28'd0, busy}, 32'h1);
        step(); step(); step();
        chk("abort_tick_pending", {31'd0, tick}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("abort_busy", {28'd0, busy}, 32'h0);
        chk("abort_expired", {28'd0, expired}, 32'h0);
        chk("abort_tick", {31'd0, tick}, 32'd0);
        chk("abort_ready", {31'd0, cfg_ready}, 32'd0);
        step();
        chk("abort_quiet", {28'd0, expired}, 32'h0);
        chk("abort_ready_back", {31'd0, cfg_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
